// File: rtl/xera4_uart_pkg.sv
// Shared definitions for the XERA4 port-mapped UART: register map,
// STATUS/CTRL bit positions, oversample timing constants and FSM encodings.
package xera4_uart_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_POP    = 2'd3;

  // STATUS bit indices
  localparam int ST_RX_AVAIL      = 0;
  localparam int ST_RX_FULL       = 1;
  localparam int ST_TX_HOLD_EMPTY = 2;
  localparam int ST_TX_IDLE       = 3;
  localparam int ST_RX_OVF        = 4;
  localparam int ST_TX_OVF        = 5;
  localparam int ST_FRAME_ERR     = 6;

  // CTRL bit indices
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  // Oversample tick counts within one bit (16 ticks per bit)
  localparam logic [3:0] TICK_LAST     = 4'd15;  // 16th tick: end of a bit
  localparam logic [3:0] TICK_MID_LAST = 4'd7;   // 8th tick: middle of start bit

  // RX state encoding
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // TX state encoding: ALIGN waits for the next tick so every bit is 16 full ticks
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ALIGN = 2'd1,
    TX_SHIFT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/xera4_uart_rx.sv
// UART receiver: 2-flop synchroniser on the asynchronous line, then a
// tick-driven FSM that samples mid-bit and reports a good byte (push) or a
// bad stop bit (frame error) as one-clock registered pulses.
module xera4_uart_rx
  import xera4_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       rxd_i,
  output logic       push_o,
  output logic [7:0] data_o,
  output logic       frame_err_o
);

  logic       sync1_q, sync2_q, prev_q;
  rx_state_e  state_q;
  logic [3:0] tcnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       push_q;
  logic       ferr_q;

  // Synchronise the line (idle high) and keep one more sample for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receive FSM: start-bit validation at tick 8, then one sample per 16 ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      tcnt_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            tcnt_q  <= 4'd0;
          end
        end
        RX_START: begin
          if (tick_i) begin
            if (tcnt_q == TICK_MID_LAST) begin
              tcnt_q <= 4'd0;
              bit_q  <= 3'd0;
              // A line that is high again by mid-start was a glitch
              state_q <= sync2_q ? RX_IDLE : RX_DATA;
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick_i) begin
            if (tcnt_q == TICK_LAST) begin
              tcnt_q  <= 4'd0;
              shift_q <= {sync2_q, shift_q[7:1]};
              if (bit_q == 3'd7) begin
                state_q <= RX_STOP;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick_i) begin
            if (tcnt_q == TICK_LAST) begin
              tcnt_q  <= 4'd0;
              push_q  <= sync2_q;
              ferr_q  <= !sync2_q;
              state_q <= RX_IDLE;
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign push_o      = push_q;
  assign data_o      = shift_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/xera4_uart.sv
// XERA4 port-mapped UART: port-bus register decode with once-per-write
// acceptance, TX holding register + shifter, RX FIFO fed by xera4_uart_rx,
// sticky status bits and a 2-clock active-low interrupt pulse on mi.
module xera4_uart
  import xera4_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          OVS_DIV   = 27,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] port_add,
  input  logic [7:0]  port_out,
  input  logic        port_we,
  output logic [7:0]  port_in,
  output logic        mi,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  // ---------------------------------------------------------------------
  // Oversample tick generator, shared by TX and RX
  // ---------------------------------------------------------------------
  logic [CW-1:0] ovs_cnt_q;
  logic          tick_q;

  // Free-running divider; tick is high for one clock per wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovs_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else if (ovs_cnt_q == CW'(OVS_DIV - 1)) begin
      ovs_cnt_q <= '0;
      tick_q    <= 1'b1;
    end else begin
      ovs_cnt_q <= ovs_cnt_q + CW'(1);
      tick_q    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Bus decode and write acceptance
  // ---------------------------------------------------------------------
  logic        prev_we_q;
  logic [15:0] prev_add_q;
  logic [7:0]  prev_out_q;
  logic        wr_acc;
  logic [15:0] off;
  logic        addr_hit;
  logic [1:0]  reg_sel;
  logic        wr_data, wr_status, wr_ctrl, wr_pop;

  // Remember the previous bus cycle so a held write is taken only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_we_q  <= 1'b0;
      prev_add_q <= 16'h0000;
      prev_out_q <= 8'h00;
    end else begin
      prev_we_q  <= port_we;
      prev_add_q <= port_add;
      prev_out_q <= port_out;
    end
  end

  assign wr_acc    = port_we && (!prev_we_q || (port_add != prev_add_q) ||
                                 (port_out != prev_out_q));
  assign off       = port_add - BASE_ADDR;
  assign addr_hit  = (off[15:2] == 14'd0);
  assign reg_sel   = off[1:0];
  assign wr_data   = wr_acc && addr_hit && (reg_sel == REG_DATA);
  assign wr_status = wr_acc && addr_hit && (reg_sel == REG_STATUS);
  assign wr_ctrl   = wr_acc && addr_hit && (reg_sel == REG_CTRL);
  assign wr_pop    = wr_acc && addr_hit && (reg_sel == REG_POP);

  // ---------------------------------------------------------------------
  // TX holding register and shifter
  // ---------------------------------------------------------------------
  tx_state_e  tx_state_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [8:0] tx_shift_q;
  logic [3:0] tx_bit_q;
  logic [3:0] tx_tcnt_q;
  logic       txd_q;
  logic       tx_load;
  logic       tx_ovf_set;

  assign tx_load    = (tx_state_q == TX_IDLE) && hold_full_q;
  // A write landing on the same edge the holding byte leaves is accepted
  assign tx_ovf_set = wr_data && hold_full_q && !tx_load;

  // Holding register: filled by DATA writes, emptied into the shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (wr_data && (!hold_full_q || tx_load)) begin
      hold_q      <= port_out;
      hold_full_q <= 1'b1;
    end else if (tx_load) begin
      hold_full_q <= 1'b0;
    end
  end

  // TX FSM: wait for a tick, then start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= 9'h1FF;
      tx_bit_q   <= 4'd0;
      tx_tcnt_q  <= 4'd0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (tx_load) begin
            tx_shift_q <= {1'b1, hold_q};
            tx_state_q <= TX_ALIGN;
          end
        end
        TX_ALIGN: begin
          if (tick_q) begin
            txd_q      <= 1'b0;
            tx_bit_q   <= 4'd0;
            tx_tcnt_q  <= 4'd0;
            tx_state_q <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tick_q) begin
            if (tx_tcnt_q == TICK_LAST) begin
              tx_tcnt_q <= 4'd0;
              if (tx_bit_q == 4'd9) begin
                tx_state_q <= TX_IDLE;
              end else begin
                txd_q      <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
              end
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 4'd1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd = txd_q;

  // ---------------------------------------------------------------------
  // RX path and FIFO
  // ---------------------------------------------------------------------
  logic          rx_push;
  logic [7:0]    rx_data;
  logic          rx_ferr;
  logic [7:0]    fifo_q [RX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full;
  logic          do_push, do_pop, rx_ovf_set;

  xera4_uart_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_q),
    .rxd_i       (uart_rxd),
    .push_o      (rx_push),
    .data_o      (rx_data),
    .frame_err_o (rx_ferr)
  );

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = wr_pop && !fifo_empty;
  // A pop on the same edge frees the slot the push needs
  assign do_push    = rx_push && (!fifo_full || do_pop);
  assign rx_ovf_set = rx_push && fifo_full && !do_pop;

  // FIFO pointers, one extra wrap bit to tell full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_ptr_q[AW-1:0]] <= rx_data;
  end

  // ---------------------------------------------------------------------
  // CTRL and sticky status
  // ---------------------------------------------------------------------
  logic [1:0] ctrl_q;
  logic       rx_ovf_q, tx_ovf_q, ferr_q;
  logic [7:0] status;

  // Control register and write-1-to-clear sticky flags (set wins over clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= 2'b00;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= port_out[1:0];
      rx_ovf_q <= rx_ovf_set || (rx_ovf_q && !(wr_status && port_out[ST_RX_OVF]));
      tx_ovf_q <= tx_ovf_set || (tx_ovf_q && !(wr_status && port_out[ST_TX_OVF]));
      ferr_q   <= rx_ferr    || (ferr_q   && !(wr_status && port_out[ST_FRAME_ERR]));
    end
  end

  // Assemble the STATUS byte
  always_comb begin
    status                   = 8'h00;
    status[ST_RX_AVAIL]      = !fifo_empty;
    status[ST_RX_FULL]       = fifo_full;
    status[ST_TX_HOLD_EMPTY] = !hold_full_q;
    status[ST_TX_IDLE]       = (tx_state_q == TX_IDLE);
    status[ST_RX_OVF]        = rx_ovf_q;
    status[ST_TX_OVF]        = tx_ovf_q;
    status[ST_FRAME_ERR]     = ferr_q;
  end

  // ---------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------
  logic [7:0] rd_data;
  logic [7:0] port_in_q;

  // Read mux for the addressed register; unmapped addresses read zero
  always_comb begin
    rd_data = 8'h00;
    if (addr_hit) begin
      case (reg_sel)
        REG_DATA:   rd_data = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[AW-1:0]];
        REG_STATUS: rd_data = status;
        REG_CTRL:   rd_data = {6'b000000, ctrl_q};
        default:    rd_data = 8'h00;
      endcase
    end
  end

  // One-clock read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) port_in_q <= 8'h00;
    else     port_in_q <= rd_data;
  end

  assign port_in = port_in_q;

  // ---------------------------------------------------------------------
  // Interrupt pulse
  // ---------------------------------------------------------------------
  logic irq_cond;
  logic irq_prev_q;
  logic irq_busy_q;
  logic mi_q;

  assign irq_cond = (ctrl_q[CTRL_RX_IE] && !fifo_empty) ||
                    (ctrl_q[CTRL_TX_IE] && !hold_full_q);

  // Rising edge of irq_cond drives mi low for two clocks; edges inside the
  // pulse are absorbed rather than extending it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q <= 1'b0;
      irq_busy_q <= 1'b0;
      mi_q       <= 1'b1;
    end else begin
      irq_prev_q <= irq_cond;
      if (irq_busy_q) begin
        irq_busy_q <= 1'b0;
      end else if (irq_cond && !irq_prev_q) begin
        mi_q       <= 1'b0;
        irq_busy_q <= 1'b1;
      end else begin
        mi_q <= 1'b1;
      end
    end
  end

  assign mi = mi_q;

endmodule

// File: tb/tb_xera4_uart.sv
// Directed-sequence bench for xera4_uart with random payloads, a serial
// decoder on uart_txd, a queue model of the RX FIFO and an mi pulse meter.
module tb_xera4_uart;

  localparam int OVS = 4;
  localparam int BIT = 16 * OVS;  // clocks per serial bit

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] port_add;
  logic [7:0]  port_out;
  logic        port_we;
  logic [7:0]  port_in;
  logic        mi;
  logic        uart_rxd;
  logic        uart_txd;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];     // bytes expected on uart_txd
  logic [7:0] tx_got[$];    // bytes decoded from uart_txd
  logic [7:0] rx_model[$];  // model of the RX FIFO contents
  logic       m_rx_ovf, m_ferr;

  int mi_pulses   = 0;
  int mi_last_len = 0;
  int mi_run      = 0;

  // Clock
  always #5 clk = ~clk;

  xera4_uart #(
    .BASE_ADDR (16'hFF00),
    .OVS_DIV   (OVS),
    .RX_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .port_add (port_add),
    .port_out (port_out),
    .port_we  (port_we),
    .port_in  (port_in),
    .mi       (mi),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  // mi pulse meter: counts completed low pulses and their width in clocks
  always @(negedge clk) begin
    if (rst) begin
      mi_run = 0;
    end else if (mi === 1'b0) begin
      mi_run++;
    end else if (mi_run != 0) begin
      mi_last_len = mi_run;
      mi_pulses++;
      mi_run = 0;
    end
  end

  // Serial decoder on uart_txd, sampling mid-bit
  initial begin : tx_mon
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge uart_txd);
      repeat (BIT / 2) @(negedge clk);
      if (uart_txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (BIT) @(negedge clk);
        if (uart_txd === 1'b1) tx_got.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    port_add = a;
    port_out = d;
    port_we  = 1'b1;
    @(negedge clk);
    port_we  = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    port_add = a;
    @(posedge clk);
    #1 d = port_in;
  endtask

  task automatic wait_tx_done(input string tag);
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      bus_read(16'hFF01, s);
      n++;
    end while (((s & 8'h0C) != 8'h0C) && (n < 40 * BIT));
    check(tag, {24'h0, s & 8'h0C}, 32'h0C);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  function automatic logic [7:0] stat_exp(input int n, input logic rov, input logic tov,
                                          input logic fe);
    return {1'b0, fe, tov, rov, 1'b1, 1'b1, (n == 4), (n != 0)};
  endfunction

  initial begin : main
    logic [7:0] r, b;
    int cnt, p0;

    rst      = 1'b1;
    port_add = 16'h0000;
    port_out = 8'h00;
    port_we  = 1'b0;
    uart_rxd = 1'b1;
    m_rx_ovf = 1'b0;
    m_ferr   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_port_in", {24'h0, port_in}, 32'h00);
    check("reset_txd", {31'h0, uart_txd}, 32'h1);
    check("reset_mi", {31'h0, mi}, 32'h1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus_read(16'hFF01, r);
    check("reset_status", {24'h0, r}, 32'h0C);
    bus_read(16'hFF02, r);
    check("reset_ctrl", {24'h0, r}, 32'h00);
    bus_read(16'hFF00, r);
    check("reset_data", {24'h0, r}, 32'h00);

    // TX of A5 with start-bit width measurement
    bus_write(16'hFF00, 8'hA5);
    exp_q.push_back(8'hA5);
    cnt = 0;
    while (uart_txd !== 1'b0 && cnt < 3 * BIT) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (uart_txd === 1'b0 && cnt < 2 * BIT) begin
      @(negedge clk);
      cnt++;
    end
    check("tx_start_bit_len", cnt, BIT);
    wait_tx_done("tx_a5_idle");

    // TX overflow: third write lands while holding register and shifter are busy
    bus_write(16'hFF00, 8'h11);
    bus_write(16'hFF00, 8'h22);
    bus_write(16'hFF00, 8'h33);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    bus_read(16'hFF01, r);
    check("tx_ovf_set", {24'h0, r & 8'h20}, 32'h20);
    wait_tx_done("tx_ovf_idle");
    bus_read(16'hFF01, r);
    check("tx_ovf_status", {24'h0, r}, 32'h2C);
    bus_write(16'hFF01, 8'h20);
    bus_read(16'hFF01, r);
    check("tx_ovf_clear", {24'h0, r}, 32'h0C);

    // Random TX bytes
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(255, 0));
      bus_write(16'hFF00, b);
      exp_q.push_back(b);
      wait_tx_done("tx_rand_idle");
    end

    // Held write enable: CTRL then DATA without dropping port_we
    @(negedge clk);
    port_add = 16'hFF02;
    port_out = 8'h03;
    port_we  = 1'b1;
    @(negedge clk);
    port_add = 16'hFF00;
    port_out = 8'h41;
    repeat (3) @(negedge clk);
    port_we = 1'b0;
    exp_q.push_back(8'h41);
    bus_read(16'hFF02, r);
    check("held_we_ctrl", {24'h0, r}, 32'h03);
    wait_tx_done("held_we_idle");
    repeat (2 * BIT) @(negedge clk);
    bus_write(16'hFF02, 8'h00);

    // Compare every decoded TX byte with the expected stream
    check("tx_count", tx_got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++)
      check("tx_byte", {24'h0, tx_got[i]}, {24'h0, exp_q[i]});

    // RX with interrupt
    bus_write(16'hFF02, 8'h01);
    bus_read(16'hFF02, r);
    check("rx_ctrl", {24'h0, r}, 32'h01);
    p0 = mi_pulses;
    send_frame(8'h3C, 1'b1);
    check("rx_mi_pulses", mi_pulses - p0, 1);
    check("rx_mi_width", mi_last_len, 2);
    bus_read(16'hFF01, r);
    check("rx_status", {24'h0, r}, 32'h0D);
    bus_read(16'hFF00, r);
    check("rx_data", {24'h0, r}, 32'h3C);
    repeat (10) @(negedge clk);
    check("rx_mi_no_repulse", mi_pulses - p0, 1);
    bus_write(16'hFF03, 8'h00);
    bus_read(16'hFF01, r);
    check("rx_pop_status", {24'h0, r}, 32'h0C);

    // RX overflow and frame error with random payloads, interrupts off
    bus_write(16'hFF02, 8'h00);
    p0 = mi_pulses;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(255, 0));
      send_frame(b, 1'b1);
      if (rx_model.size() < 4) rx_model.push_back(b);
      else                     m_rx_ovf = 1'b1;
    end
    send_frame(8'($urandom_range(255, 0)), 1'b0);
    m_ferr = 1'b1;
    check("rx_no_mi", mi_pulses - p0, 0);
    bus_read(16'hFF01, r);
    check("rx_full_status", {24'h0, r},
          {24'h0, stat_exp(rx_model.size(), m_rx_ovf, 1'b0, m_ferr)});
    while (rx_model.size() != 0) begin
      bus_read(16'hFF00, r);
      check("rx_fifo_byte", {24'h0, r}, {24'h0, rx_model[0]});
      void'(rx_model.pop_front());
      bus_write(16'hFF03, 8'h00);
    end
    bus_write(16'hFF03, 8'h5A);
    bus_read(16'hFF00, r);
    check("rx_empty_data", {24'h0, r}, 32'h00);
    bus_read(16'hFF01, r);
    check("rx_drained_status", {24'h0, r},
          {24'h0, stat_exp(0, m_rx_ovf, 1'b0, m_ferr)});
    bus_write(16'hFF01, 8'h70);
    bus_read(16'hFF01, r);
    check("rx_sticky_clear", {24'h0, r}, 32'h0C);
    bus_read(16'hFF04, r);
    check("unmapped_read", {24'h0, r}, 32'h00);

    // Reset in the middle of a TX frame and an RX frame
    bus_write(16'hFF00, 8'h00);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check("pre_reset_txd_low", {31'h0, uart_txd}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_txd", {31'h0, uart_txd}, 32'h1);
    check("mid_reset_mi", {31'h0, mi}, 32'h1);
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    bus_read(16'hFF01, r);
    check("post_reset_status", {24'h0, r}, 32'h0C);
    bus_read(16'hFF00, r);
    check("post_reset_data", {24'h0, r}, 32'h00);
    check("post_reset_txd", {31'h0, uart_txd}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xera4_uart.md
# xera4_uart

Port-mapped UART peripheral for the XERA4 CPU's I/O port bus. It consumes CPU port writes (address, data, write enable) and returns register contents on the port read bus. It serialises TX bytes and deserialises RX bytes into a 4-deep FIFO. It signals the CPU through the active-low MI interrupt line, which the CPU detects as a low-then-high edge.

## Interface
Parameters:
- BASE_ADDR, 16'hFF00, base port address; the block decodes BASE_ADDR+0..+3.
- OVS_DIV, 27, clocks per 16x-oversample tick. 50 MHz / 115200 / 16 ≈ 27.
- RX_DEPTH, 4, RX FIFO entries (power of two).

Ports:
- clk  in  1  system clock; every flop in the block is posedge.
- rst  in  1  reset, asynchronous, active-high.
- port_add  in  16  CPU port address.
- port_out  in  8  CPU write data.
- port_we  in  1  CPU port write enable. The CPU may hold it high across several writes.
- port_in  out  8  registered read data for port_add.
- mi  out  1  interrupt request to the CPU, active-low pulse.
- uart_rxd  in  1  serial input, asynchronous, idle high.
- uart_txd  out  1  serial output, idle high.

## Operation
Registers (offset from BASE_ADDR):
- +0 DATA
  - Write: load the TX holding register.
  - Read: head of the RX FIFO, non-destructive. Reads 8'h00 when the FIFO is empty.
- +1 STATUS
  - Read bits: 0 rx_avail, 1 rx_full, 2 tx_hold_empty, 3 tx_idle, 4 rx_ovf, 5 tx_ovf, 6 frame_err, 7 = 0.
  - Write: write-1-to-clear on bits 4..6.
- +2 CTRL, read/write.
  - bit0: RX interrupt enable.
  - bit1: TX-empty interrupt enable.
  - bits 7..2: read 0.
- +3 POP, write-only, any data. Discards the RX FIFO head; no effect when the FIFO is empty. Reads 8'h00.
- Other addresses: port_in = 8'h00. Writes are ignored.

Write acceptance:
- A write is accepted on a posedge where port_we=1 and either:
  - port_we was 0 on the previous posedge, or
  - port_add or port_out differs from its value on the previous posedge.
- Each distinct bus write is therefore accepted exactly once, even if port_we is held high.

TX:
- A DATA write while the holding register is empty fills the holding register.
- A DATA write while the holding register is full is dropped and sets tx_ovf.
- When the shifter is idle and the holding register is full, the byte moves to the shifter the next cycle.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts 16 ticks.

RX:
- uart_rxd passes through a 2-flop synchroniser.
- States: IDLE, START, DATA, STOP.
- IDLE → START on a sampled falling edge.
- START: at tick 8, rxd=0 → DATA. Otherwise the start is false; return to IDLE and push nothing.
- DATA: 8 samples, one every 16 ticks, placed LSB first.
- STOP: sampled 16 ticks after the last data bit.
  - rxd=1: push the byte.
  - rxd=0: set frame_err, discard the byte.
  - Either case → IDLE.
- Push while the FIFO is full: the byte is dropped and rx_ovf is set.
- Simultaneous push and POP on a full FIFO: both take effect and no overflow is raised.

Interrupt:
- irq_cond = (CTRL[0] & rx_avail) | (CTRL[1] & tx_hold_empty).
- On each 0→1 transition of irq_cond, mi goes low for exactly 2 clocks, then returns high.
- A new rising edge during the pulse does not extend it.
- A level-held condition does not re-pulse. Software clears the condition (POP, or a DATA write) to re-arm.

## Timing
- Reset values:
  - uart_txd=1, mi=1, port_in=8'h00, CTRL=0.
  - FIFO empty, holding register empty, sticky bits 0, RX in IDLE, oversample counter 0.
- Reset asserted mid-frame aborts TX and RX immediately. uart_txd goes to 1 asynchronously.
- port_in is registered: it reflects port_add and register state from the previous posedge, so read latency is 1 clock.
- An accepted write updates register state at that posedge. Status is visible on port_in 2 posedges after the write edge.
- The tick counter counts 0..OVS_DIV-1 and wraps, then emits a 1-clock tick. It is free-running and shared by TX and RX.
- TX start latency: up to 1 clock for holding→shifter, plus up to one tick for alignment.
- Frame length is 160 ticks. tx_idle=1 from the end of the stop bit.
- RX push occurs on the stop-sample tick. rx_avail is visible on port_in 1 clock later. mi falls 1 clock after rx_avail rises.
- FIFO pointers are log2(RX_DEPTH)+1 bits wide and wrap modulo 2*RX_DEPTH.
  - full: MSBs differ and the rest are equal.
  - empty: the pointers are equal.

## Structure
- Shared package xera4_uart_pkg holds:
  - register offsets (DATA=0, STATUS=1, CTRL=2, POP=3);
  - STATUS bit indices;
  - CTRL bit indices;
  - the RX state encoding.
- One sub-module, xera4_uart_rx, contains the synchroniser, the RX FSM and the frame_err/push outputs.
- TX, FIFO, register decode and interrupt logic live in xera4_uart.

## Test plan
- TX:
  - Stimulus: CTRL=0; write 8'hA5 to FF00.
  - Response: uart_txd shows 0, 1,0,1,0,0,1,0,1, 1 at 16*OVS_DIV clocks per bit; tx_idle returns to 1.
- TX overflow:
  - Stimulus: write 8'h11 then 8'h22 then 8'h33 back-to-back.
  - Response: 11 and 22 are transmitted, 33 is dropped, STATUS bit5=1; writing 8'h20 to FF01 clears it.
- RX with interrupt:
  - Stimulus: CTRL=8'h01; drive frame 8'h3C on uart_rxd.
  - Response: mi low for exactly 2 clocks; FF01 reads 8'h0D (rx_avail, tx_hold_empty, tx_idle); FF00 reads 8'h3C; write FF03 → rx_avail=0.
- RX overflow and frame error:
  - Stimulus: send 5 frames with no POP; send one frame with stop bit 0.
  - Response: the FIFO holds the first 4 bytes, rx_full=1, rx_ovf=1; the bad frame is not pushed and frame_err=1.
- Held write enable:
  - Stimulus: port_we held high while port_add changes FF02 → FF00 with data 8'h03 → 8'h41.
  - Response: CTRL=8'h03, one TX of 8'h41, no duplicate writes.
- Reset:
  - Stimulus: assert rst mid-TX and mid-RX frame.
  - Response: uart_txd=1, mi=1, STATUS reads 8'h0C after deassertion.
